// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and variable-latency load
// results onto one registered register-file write port, queueing losing loads.
module wb_arbiter #(
  parameter int DATA_N     = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [DATA_N-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [DATA_N-1:0]        mem_data,
  output logic                     wr_en,
  output logic [4:0]               w_addr,
  output logic [DATA_N-1:0]        w_data,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  // Both sources use valid/ready: a transfer happens on a rising edge where
  // valid && ready; ready never depends on the same cycle's valid inputs.

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int EW = 5 + DATA_N;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [EW-1:0]     fifo_q [DEPTH];
  logic [AW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              wr_en_q, wr_en_d;
  logic [4:0]        w_addr_q, w_addr_d;
  logic [DATA_N-1:0] w_data_q, w_data_d;

  logic          fifo_empty, alu_fire, mem_fire, alu_win, pop, bypass, push;
  logic [EW-1:0] head;

  always_comb begin
    fifo_empty = (count_q == '0);
    mem_ready  = (count_q != FULL);
    alu_ready  = !(!fifo_empty && (starve_q == SMAX));
    alu_fire   = alu_valid && alu_ready;
    mem_fire   = mem_valid && mem_ready;
    alu_win    = alu_fire && (alu_rd != 5'd0);
    pop        = !alu_win && !fifo_empty;
    bypass     = !alu_win && fifo_empty && mem_fire && (mem_rd != 5'd0);
    push       = mem_fire && (mem_rd != 5'd0) && !bypass;
    head       = fifo_q[rptr_q];

    wr_en_d  = alu_win || pop || bypass;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (alu_win) begin
      w_addr_d = alu_rd;
      w_data_d = alu_data;
    end else if (pop) begin
      w_addr_d = head[EW-1:DATA_N];
      w_data_d = head[DATA_N-1:0];
    end else if (bypass) begin
      w_addr_d = mem_rd;
      w_data_d = mem_data;
    end

    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    count_d = count_q + CW'(push) - CW'(pop);

    // Starvation only accrues while a load is actually waiting behind the ALU.
    if (fifo_empty || pop)
      starve_d = '0;
    else if (alu_win && (starve_q != SMAX))
      starve_d = starve_q + 1'b1;
    else
      starve_d = starve_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q   <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      wr_en_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wr_en_q  <= wr_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      fifo_q[wptr_q] <= {mem_rd, mem_data};
  end

  assign wr_en      = wr_en_q;
  assign w_addr     = w_addr_q;
  assign w_data     = w_data_q;
  assign fifo_count = count_q;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file write port (wr_en, w_addr, w_data).
- Merges two result sources into the single write port:
  - single-cycle ALU results;
  - variable-latency load results from the data-memory interface.
- Load results that lose arbitration wait in an internal FIFO.
- A starvation counter guarantees the FIFO drains even under continuous ALU traffic.

Parameters:
- DATA_N, 32, data width of results and w_data.
- DEPTH, 4, load-result FIFO entries (power of two, >=2).
- STARVE_MAX, 3, consecutive ALU wins allowed while FIFO non-empty before ALU is blocked.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid&alu_ready.
- alu_rd  in  5  ALU destination register.
- alu_data  in  DATA_N  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  load result accepted when mem_valid&mem_ready.
- mem_rd  in  5  load destination register.
- mem_data  in  DATA_N  load data.
- wr_en  out  1  register file write enable (registered).
- w_addr  out  5  register file write address (registered).
- w_data  out  DATA_N  register file write data (registered).
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at clk edge):
  - wr_en=0, w_addr=0, w_data=0.
  - FIFO emptied (fifo_count=0); starve_cnt=0.
  - Reset mid-operation discards all queued loads. No write is issued in the cycle after reset.
- Handshake outputs (combinational):
  - mem_ready = (fifo_count != DEPTH). No pass-through while full.
  - alu_ready = !(fifo_count != 0 && starve_cnt == STARVE_MAX).
- Write candidates: ALU transfer with alu_rd != 0; FIFO head; mem bypass.
- x0 handling: a transfer with rd==0 completes its handshake, is never written, never enters the FIFO, and does not consume the write slot.
- Per-cycle priority for the single write slot:
  1. ALU transfer with alu_rd != 0.
  2. Else FIFO head, if FIFO non-empty (pop).
  3. Else accepted mem transfer (mem_rd != 0) while FIFO empty: bypass, not pushed.
- Any accepted mem transfer (mem_rd != 0) that does not win the slot is pushed at the FIFO tail.
- Push and pop in the same cycle leave fifo_count unchanged; order is strictly FIFO.
- Output latency: the winner appears on wr_en/w_addr/w_data exactly 1 cycle after its acceptance/pop edge. wr_en=0 in any cycle following a cycle with no winner; w_addr/w_data hold their last values.
- Starvation counter starve_cnt (0..STARVE_MAX):
  - +1 on each ALU write while the FIFO is non-empty.
  - Cleared on any FIFO pop, or when the FIFO is empty.
  - At STARVE_MAX, alu_ready=0, so the FIFO head wins next.
- Ordering: no hazard checking between the sources; the issue logic guarantees no WAW between an outstanding load and a younger ALU op.

Test Plan:
- Reset: hold rst 2 cycles with alu_valid=1, mem_valid=1 -> wr_en=0, w_addr=0, w_data=0, fifo_count=0; first write appears 1 cycle after rst drops.
- ALU only: alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> next cycle wr_en=1, w_addr=5, w_data=0xDEADBEEF; then wr_en=0.
- Collision: alu_rd=3/0x11 and mem_rd=7/0x22 in the same cycle -> cycle+1 writes x3=0x11; fifo_count=1; cycle+2 writes x7=0x22; fifo_count=0.
- Full FIFO: continuous ALU traffic plus 5 loads -> mem_ready=0 once fifo_count=4. Starvation: after 3 ALU writes with the FIFO non-empty, alu_ready=0 for one cycle and the head load is written; loads are written in arrival order.
- x0: alu_rd=0 with mem_rd=9/0x55 in the same cycle -> no x0 write; x9=0x55 written next cycle via bypass; fifo_count stays 0.
- Reset mid-operation: fifo_count=3, assert rst -> fifo_count=0, queued loads never written, wr_en=0.
